regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file with a pending-write scoreboard for the pipelined core. It provides NRD combinational read ports and two synchronous write ports (ALU writeback and load writeback). A per-register busy bit is set when the issue stage allocates a destination and cleared on writeback, so hazard logic can stall on busy sources. An optional write-to-read bypass is compiled in by macro.

## Interface
- XLEN, 32: data width in bits.
- NREG, 32: number of architectural registers; power of two, minimum 2.
- AW, $clog2(NREG): register address width (derived).
- NRD, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 means register 0 reads 0, ignores writes and is never busy.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data.
- rd_busy  out  NRD  busy bit of each read port's addressed register.
- wr0_en, wr1_en  in  1  write enables. Port 0 is ALU writeback; port 1 is load writeback.
- wr0_addr, wr1_addr  in  AW  write addresses.
- wr0_data, wr1_data  in  XLEN  write data.
- iss_en  in  1  issue: mark iss_addr busy.
- iss_addr  in  AW  destination being allocated.
- busy_vec  out  NREG  full scoreboard, bit i = register i busy.

## Operation
- Storage is NREG x XLEN flops.
- Reset (async) clears all registers to 0 and all busy bits to 0.
  - While rst=1, writes and issues are ignored.
  - Outputs during reset: rd_data=0, rd_busy=0, busy_vec=0.
- Read:
  - rd_data[k] = reg[rd_addr[k]], combinational.
  - If ZERO_REG=1 and the address is 0, rd_data[k]=0 and rd_busy[k]=0.
- Write:
  - At each posedge, every enabled port writes its data.
  - If both ports target the same address, port 1 wins and the port 0 data is dropped.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Scoreboard, evaluated per register at each posedge:
  - Clear if any enabled write port targets the register.
  - Set if iss_en targets the register.
  - Set and clear on the same register in the same cycle: set wins (a new producer is allocated behind the retiring one).
  - A write to a non-busy register is legal: data is written, busy stays 0.
  - iss_en on an already-busy register: busy stays 1, no error.
- Address decoding: all addresses are used modulo NREG (no out-of-range case when NREG is a power of two).

## Timing
- Read latency is 0 cycles (combinational from rd_addr).
- A write is visible on rd_data in the cycle after its posedge.
  - With REGFILE_BYPASS_EN defined, it is visible in the same cycle (see Configuration).
- Busy set/clear takes effect at the posedge and is visible on rd_busy/busy_vec from the next cycle.
  - The scoreboard has no bypass.
- rst asserted mid-cycle clears state immediately, with no clock needed.
- Deassertion of rst is synchronous to clk, supplied by the top level. The first write is accepted on the first posedge with rst=0.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: on a read-address match against an enabled write port in the same cycle, rd_data returns the write data.
  - Port 1 data takes precedence over port 0.
  - Address 0 is never bypassed when ZERO_REG=1.
  - rd_busy is unaffected: it still shows the registered value.
- Not defined: rd_data always shows the stored value, so same-cycle write data appears one cycle later.

## Test plan
- Reset: write reg5=0xDEADBEEF, pulse rst between clock edges -> rd_data for addr 5 = 0 immediately; busy_vec=0.
- Dual write collision: wr0 (addr 7, 0x11111111) and wr1 (addr 7, 0x22222222) in the same cycle -> next cycle reg7 reads 0x22222222.
- Zero register: wr0 (addr 0, 0xFFFFFFFF), iss_en addr 0 -> rd_data=0, rd_busy=0, busy_vec[0]=0.
- Scoreboard: iss addr 3 at cycle 0 -> busy_vec[3]=1 from cycle 1; wr1 addr 3 at cycle 4 -> busy_vec[3]=0 from cycle 5.
- Set/clear race: reg9 busy, then iss_en addr 9 and wr0 addr 9 (0xA5A5A5A5) in the same cycle -> next cycle reg9=0xA5A5A5A5 and busy_vec[9]=1.
- Bypass: wr0 addr 12 = 0xCAFEF00D with rd_addr[0]=12 in the same cycle -> rd_data[0]=0xCAFEF00D in that cycle with REGFILE_BYPASS_EN defined, old value (0) without it.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a pending-write (busy) scoreboard.
// Optional same-cycle write-to-read bypass is compiled in with REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW       = $clog2(NREG),
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regsQ [NREG];
    logic [NREG-1:0] busyQ;

    // Storage and scoreboard, one slice per architectural register
    for (genvar i = 0; i < NREG; i++) begin : gReg
        if (ZERO_REG != 0 && i == 0) begin : gZero
            assign regsQ[i] = '0;
            assign busyQ[i] = 1'b0;
        end else begin : gFlop
            localparam logic [AW-1:0] Idx = AW'(i);

            logic            hit0;
            logic            hit1;
            logic            issHit;
            logic [XLEN-1:0] dataQ;
            logic [XLEN-1:0] dataD;
            logic            busyBitQ;
            logic            busyBitD;

            assign hit0   = wr0_en && (wr0_addr == Idx);
            assign hit1   = wr1_en && (wr1_addr == Idx);
            assign issHit = iss_en && (iss_addr == Idx);

            always_comb begin
                dataD    = dataQ;
                busyBitD = busyBitQ;
                if (hit1) begin
                    dataD = wr1_data;
                end else if (hit0) begin
                    dataD = wr0_data;
                end
                if (hit0 || hit1) begin
                    busyBitD = 1'b0;
                end
                // A new producer allocated behind the retiring one keeps the bit set
                if (issHit) begin
                    busyBitD = 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dataQ    <= '0;
                    busyBitQ <= 1'b0;
                end else begin
                    dataQ    <= dataD;
                    busyBitQ <= busyBitD;
                end
            end

            assign regsQ[i] = dataQ;
            assign busyQ[i] = busyBitQ;
        end
    end

    assign busy_vec = busyQ;

    // Read ports
    for (genvar k = 0; k < NRD; k++) begin : gRead
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            isZero;

        assign addr   = rd_addr[k*AW +: AW];
        assign isZero = (ZERO_REG != 0) && (addr == '0);

        always_comb begin
            data = regsQ[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr1_en && (wr1_addr == addr)) begin
                data = wr1_data;
            end else if (wr0_en && (wr0_addr == addr)) begin
                data = wr0_data;
            end
`endif
            // Bypassed write data must not leak out while in reset
            if (isZero || rst) begin
                data = '0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_busy[k]              = busyQ[addr] & ~isZero;
    end

endmodule
